// File: rtl/imdct_sched_pkg.sv
// Shared definitions for the IMDCT frame scheduler: FSM encoding, default
// parameters and the job record layout {base, tag} held in the job FIFO.
package imdct_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARM  = 3'd1,
      ST_FIRE = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4
   } sched_state_e;

   localparam int DEF_DEPTH   = 4;
   localparam int DEF_RST_CYC = 4;
   localparam int DEF_TIMEOUT = 2048;
   localparam int DEF_TAG_W   = 8;
   localparam int BASE_W      = 32;

   // Width of one FIFO entry: base in the upper bits, tag in the lower bits.
   function automatic int job_w(input int tag_w);
      return BASE_W + tag_w;
   endfunction

endpackage

// File: rtl/imdct_frame_sched_if.sv
// Host-side job/completion handshake bundle for the IMDCT frame scheduler.
// master = host (offers jobs, consumes completions), slave = scheduler.
interface imdct_frame_sched_if
   import imdct_sched_pkg::*;
#(
   parameter int TAG_W = DEF_TAG_W
) ();

   logic              job_valid;
   logic              job_ready;
   logic [BASE_W-1:0] job_base;
   logic [TAG_W-1:0]  job_tag;
   logic              done_valid;
   logic              done_ready;
   logic [TAG_W-1:0]  done_tag;
   logic              done_err;

   modport master (
      output job_valid, job_base, job_tag, done_ready,
      input  job_ready, done_valid, done_tag, done_err
   );

   modport slave (
      input  job_valid, job_base, job_tag, done_ready,
      output job_ready, done_valid, done_tag, done_err
   );

endinterface

// File: rtl/imdct_frame_sched_fifo.sv
// Synchronous job FIFO (DEPTH x W) with registered full/empty flags.
// Push while full and pop while empty are ignored.
module sched_job_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 40
) (
   input  logic         clk_in,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic          r_full;
   logic          r_empty;
   logic [AW-1:0] w_wr_nxt;
   logic [AW-1:0] w_rd_nxt;
   logic          w_push;
   logic          w_pop;

   assign w_push   = i_push & ~r_full;
   assign w_pop    = i_pop & ~r_empty;
   assign w_wr_nxt = r_wr_ptr + 1'b1;
   assign w_rd_nxt = r_rd_ptr + 1'b1;

   // NOTE: storage is deliberately not reset; the pointers and flags alone
   // decide which entries are valid, so clearing the array buys nothing.
   always_ff @(posedge clk_in) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= w_wr_nxt;
         if (w_pop)  r_rd_ptr <= w_rd_nxt;
         if (w_push && !w_pop) begin
            r_empty <= 1'b0;
            r_full  <= (w_wr_nxt == r_rd_ptr);
         end else if (w_pop && !w_push) begin
            r_full  <= 1'b0;
            r_empty <= (w_rd_nxt == r_wr_ptr);
         end
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/imdct_frame_sched.sv
// Frame scheduler: queues host jobs, resets and starts the IMDCT engine once
// per frame, watches its done flag with a watchdog and reports completions.
module imdct_frame_sched
   import imdct_sched_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int RST_CYC = DEF_RST_CYC,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int TAG_W   = DEF_TAG_W
) (
   input  logic              clk_in,
   input  logic              rst_n,
   imdct_frame_sched_if.slave job,
   output logic              engine_rst_n,
   output logic              engine_start,
   input  logic              engine_intr,
   output logic [BASE_W-1:0] bram_base,
   output logic              irq,
   input  logic              intr_clr,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int JOB_W = job_w(TAG_W);
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam int AC_W  = $clog2(RST_CYC + 1);

   sched_state_e      r_state;
   sched_state_e      w_next;
   logic [AC_W-1:0]   r_arm_cnt;
   logic [WD_W-1:0]   r_wdog;
   logic              r_intr_q;
   logic [BASE_W-1:0] r_base;
   logic [TAG_W-1:0]  r_tag;
   logic              r_err;
   logic              r_irq;
   logic [15:0]       r_frame_cnt;

   logic              w_fifo_push;
   logic              w_fifo_pop;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [JOB_W-1:0]  w_fifo_head;
   logic              w_intr_edge;
   logic              w_timeout;
   logic              w_enter_done;
   logic              w_eng_rst_n;
   logic              w_start;
   logic              w_done_valid;

   sched_job_fifo #(
      .DEPTH(DEPTH),
      .W    (JOB_W)
   ) u_fifo (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .i_push (w_fifo_push),
      .i_data ({job.job_base, job.job_tag}),
      .i_pop  (w_fifo_pop),
      .o_data (w_fifo_head),
      .o_full (w_fifo_full),
      .o_empty(w_fifo_empty)
   );

   // Ready and engine reset are gated by rst_n so both read low while reset is held.
   assign job.job_ready = rst_n & ~w_fifo_full;
   assign w_fifo_push   = job.job_valid & job.job_ready;
   assign w_fifo_pop    = (r_state == ST_IDLE) & ~w_fifo_empty;
   assign w_intr_edge   = engine_intr & ~r_intr_q;
   assign w_timeout     = (r_wdog == WD_W'(TIMEOUT - 1));
   assign w_enter_done  = (r_state == ST_RUN) & (w_intr_edge | w_timeout);

   always_ff @(posedge clk_in) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch
      // can leave one unassigned and infer a latch.
      w_next       = r_state;
      w_eng_rst_n  = 1'b1;
      w_start      = 1'b0;
      w_done_valid = 1'b0;
      case (r_state)
         ST_IDLE: if (!w_fifo_empty) w_next = ST_ARM;
         ST_ARM: begin
            w_eng_rst_n = 1'b0;
            if (r_arm_cnt == AC_W'(RST_CYC - 1)) w_next = ST_FIRE;
         end
         ST_FIRE: begin
            w_start = 1'b1;
            w_next  = ST_RUN;
         end
         ST_RUN:  if (w_enter_done) w_next = ST_DONE;
         ST_DONE: begin
            w_done_valid = 1'b1;
            if (job.done_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // The watchdog is cleared in ARM and counts from the start cycle, so it
   // holds the number of cycles elapsed since the start pulse.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_arm_cnt   <= '0;
         r_wdog      <= '0;
         r_intr_q    <= 1'b0;
         r_base      <= '0;
         r_tag       <= '0;
         r_err       <= 1'b0;
         r_irq       <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_intr_q  <= engine_intr;
         r_arm_cnt <= (r_state == ST_ARM) ? r_arm_cnt + 1'b1 : '0;
         r_wdog    <= (r_state == ST_FIRE || r_state == ST_RUN) ? r_wdog + 1'b1 : '0;
         if (w_fifo_pop) {r_base, r_tag} <= w_fifo_head;
         if (w_enter_done) begin
            r_err <= ~w_intr_edge;
            if (w_intr_edge) r_frame_cnt <= r_frame_cnt + 1'b1;
         end
         if (w_enter_done)  r_irq <= 1'b1;
         else if (intr_clr) r_irq <= 1'b0;
      end
   end

   assign engine_rst_n   = rst_n & w_eng_rst_n;
   assign engine_start   = w_start;
   assign bram_base      = r_base;
   assign job.done_valid = w_done_valid;
   assign job.done_tag   = r_tag;
   assign job.done_err   = r_err;
   assign irq            = r_irq;
   assign busy           = (r_state != ST_IDLE) | ~w_fifo_empty;
   assign frame_cnt      = r_frame_cnt;

endmodule
